multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Multicycle successor to the single-cycle main decoder. A Moore FSM sequences each instruction through fetch, decode, execute, memory and write-back. It drives the datapath control lines per state, stalls on a memory-ready handshake, traps illegal opcodes and counts retired instructions. It sits between the instruction register's opcode field and the shared-memory multicycle datapath.

Parameters:
OPCODE_W, 6, opcode field width
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b110001, load-word opcode
OP_SW, 6'b110101, store-word opcode
OP_BEQ, 6'b001000, branch-if-equal opcode
OP_J, 6'b000010, jump opcode
ENABLE_JUMP, 1, 1 = OP_J decoded; 0 = OP_J is illegal
MEM_HANDSHAKE, 1, 1 = memory states wait for memReady; 0 = memReady treated as constant 1
COUNT_W, 16, width of retired-instruction counter

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
opCode  in  OPCODE_W  opcode from instruction register, sampled in DECODE
memReady  in  1  memory access completes this cycle
pcWrite  out  1  unconditional PC load
pcWriteCond  out  1  PC load if ALU zero
iorD  out  1  0 = memory address from PC, 1 = from ALU out
memRead  out  1  memory read strobe
memWrite  out  1  memory write strobe
irWrite  out  1  instruction register load
memToReg  out  1  register write data from memory data register
regDest  out  1  1 = rd, 0 = rt
regWrite  out  1  register file write
aluSrcA  out  1  0 = PC, 1 = rs
aluSrcB  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
aluOp  out  2  00 add, 01 sub, 10 funct-decoded
pcSource  out  2  00 ALU result, 01 ALU out register, 10 jump target
illegal  out  1  sticky trap flag
instrDone  out  1  one-cycle pulse when an instruction retires
retireCount  out  COUNT_W  retired-instruction count, wraps
state  out  4  current state encoding, for debug

Behaviour:
- Clocking: all state updates on rising clock. Outputs are combinational from the state register, plus memReady qualification where noted. There are no other input-to-output paths.
- Reset: while reset=1, next state is S_RESET and retireCount clears to 0. In S_RESET every output is 0 (state=0). S_RESET always moves to S_FETCH on the next cycle. A reset asserted mid-instruction abandons it with no retire.
- Unlisted outputs are 0 in every state.
- S_FETCH:
  - memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00.
  - irWrite=pcWrite=memReady.
  - If memReady, go to S_DECODE; otherwise stay.
- S_DECODE: aluSrcA=0, aluSrcB=11, aluOp=00. Next state by opCode:
  - RTYPE goes to S_EXEC.
  - LW or SW goes to S_MEMADDR.
  - BEQ goes to S_BRANCH.
  - J goes to S_JUMP if ENABLE_JUMP, otherwise S_TRAP.
  - Any other opcode goes to S_TRAP.
- S_MEMADDR: aluSrcA=1, aluSrcB=10, aluOp=00. Goes to S_MEMRD if the opcode was LW, otherwise S_MEMWR. The opcode is latched in DECODE; later changes on opCode are ignored.
- S_MEMRD: memRead=1, iorD=1. Waits for memReady, then goes to S_MEMWB.
- S_MEMWB: regDest=0, memToReg=1, regWrite=1, instrDone=1. Goes to S_FETCH.
- S_MEMWR: memWrite=1, iorD=1. instrDone=memReady. Goes to S_FETCH on memReady, otherwise stays. memWrite stays high through the whole stall.
- S_EXEC: aluSrcA=1, aluSrcB=00, aluOp=10. Goes to S_RWB.
- S_RWB: regDest=1, regWrite=1, memToReg=0, instrDone=1. Goes to S_FETCH.
- S_BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01, instrDone=1. Goes to S_FETCH.
- S_JUMP: pcWrite=1, pcSource=10, instrDone=1. Goes to S_FETCH.
- S_TRAP: illegal=1, all other controls 0. Absorbing; only reset exits. Not counted as a retire.
- Latency with memReady always 1, in cycles from FETCH entry to the instrDone cycle inclusive:
  - R-type 4
  - LW 5
  - SW 4
  - BEQ 3
  - J 3
- Each memReady=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- retireCount increments by 1 in every cycle where instrDone=1. It wraps from 2^COUNT_W-1 to 0.
- Encoding, fixed:
  - RESET=0, FETCH=1, DECODE=2, MEMADDR=3, MEMRD=4
  - MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9
  - JUMP=10, TRAP=15
  - Unused codes recover to S_FETCH on the next cycle.

Decomposition:
- Shared package holds:
  - state localparams and 4-bit state type
  - aluSrcB, aluOp and pcSource code constants
  - default opcode constants, which the single-cycle decoder also uses
- Optional sub-module control_output_decode: purely combinational, state plus memReady to control lines. FSM next-state logic and the counter stay in multicycle_control.

Test Plan:
- Reset, then opCode=000000 with memReady=1 -> states 0,1,2,7,8,1. In RWB regWrite=1, regDest=1, instrDone=1. retireCount=1.
- LW 110001 with memReady held 0 for 3 cycles in MEMRD -> MEMRD lasts 4 cycles with memRead=iorD=1 throughout. MEMWB memToReg=1, regWrite=1. Total 8 cycles.
- SW 110101 then BEQ 001000 -> memWrite=1 only in MEMWR. BRANCH has pcWriteCond=1, aluOp=01, pcSource=01. retireCount=2 after both.
- FETCH with memReady=0 for 2 cycles -> irWrite=pcWrite=0 during the stall, 1 in the ready cycle, and the state stays 1 until then.
- opCode=111111, and separately 000010 with ENABLE_JUMP=0 -> TRAP (state=15), illegal=1 held for 10 cycles, no instrDone. Reset clears it to state 0 with all outputs 0.
- COUNT_W=2, five R-type instructions -> retireCount sequence 1,2,3,0,1. Reset asserted in S_EXEC -> next state 0, count 0, no retire.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle controller: state encoding, datapath
// mux/ALU codes and the default opcode values also used by the single-cycle decoder.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADDR = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_RWB     = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_TRAP    = 4'd15
  } state_t;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [5:0] DEF_OP_RTYPE = 6'b000000;
  localparam logic [5:0] DEF_OP_LW    = 6'b110001;
  localparam logic [5:0] DEF_OP_SW    = 6'b110101;
  localparam logic [5:0] DEF_OP_BEQ   = 6'b001000;
  localparam logic [5:0] DEF_OP_J     = 6'b000010;

endpackage

// File: rtl/multicycle_control_output_decode.sv
// Moore output decode for the multicycle controller: state plus memory-ready
// qualification to datapath control lines. Purely combinational.
module multicycle_control_output_decode
  import multicycle_control_pkg::*;
(
  input  state_t     st,
  input  logic       ready,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regDest,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic       illegal,
  output logic       instrDone
);

  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memToReg    = 1'b0;
    regDest     = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = SRCB_RT;
    aluOp       = ALU_ADD;
    pcSource    = PC_ALU;
    illegal     = 1'b0;
    instrDone   = 1'b0;
    case (st)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = SRCB_FOUR;
        irWrite = ready;
        pcWrite = ready;
      end
      S_DECODE:  aluSrcB = SRCB_IMM_SH;
      S_MEMADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      S_MEMWB: begin
        memToReg  = 1'b1;
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      // memWrite is held for the whole stall; retire only on the completing cycle
      S_MEMWR: begin
        memWrite  = 1'b1;
        iorD      = 1'b1;
        instrDone = ready;
      end
      S_EXEC: begin
        aluSrcA = 1'b1;
        aluOp   = ALU_FUNCT;
      end
      S_RWB: begin
        regDest   = 1'b1;
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = ALU_SUB;
        pcWriteCond = 1'b1;
        pcSource    = PC_ALUOUT;
        instrDone   = 1'b1;
      end
      S_JUMP: begin
        pcWrite   = 1'b1;
        pcSource  = PC_JUMP;
        instrDone = 1'b1;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/write-back,
// stalls on memReady, traps illegal opcodes and counts retired instructions.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int                    OPCODE_W      = 6,
  parameter logic [OPCODE_W-1:0]   OP_RTYPE      = DEF_OP_RTYPE,
  parameter logic [OPCODE_W-1:0]   OP_LW         = DEF_OP_LW,
  parameter logic [OPCODE_W-1:0]   OP_SW         = DEF_OP_SW,
  parameter logic [OPCODE_W-1:0]   OP_BEQ        = DEF_OP_BEQ,
  parameter logic [OPCODE_W-1:0]   OP_J          = DEF_OP_J,
  parameter bit                    ENABLE_JUMP   = 1'b1,
  parameter bit                    MEM_HANDSHAKE = 1'b1,
  parameter int                    COUNT_W       = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opCode,
  input  logic                memReady,
  output logic                pcWrite,
  output logic                pcWriteCond,
  output logic                iorD,
  output logic                memRead,
  output logic                memWrite,
  output logic                irWrite,
  output logic                memToReg,
  output logic                regDest,
  output logic                regWrite,
  output logic                aluSrcA,
  output logic [1:0]          aluSrcB,
  output logic [1:0]          aluOp,
  output logic [1:0]          pcSource,
  output logic                illegal,
  output logic                instrDone,
  output logic [COUNT_W-1:0]  retireCount,
  output logic [3:0]          state
);

  state_t cur, nxt;
  logic   ready;
  logic   is_lw;

  assign ready = MEM_HANDSHAKE ? memReady : 1'b1;
  assign state = cur;

  always_ff @(posedge clock) begin
    if (reset) cur <= S_RESET;
    else       cur <= nxt;
  end

  // Only the LW/SW distinction is needed after DECODE, so keep just that bit
  always_ff @(posedge clock) begin
    if (cur == S_DECODE) is_lw <= (opCode == OP_LW);
  end

  always_ff @(posedge clock) begin
    if (reset)          retireCount <= '0;
    else if (instrDone) retireCount <= retireCount + COUNT_W'(1);
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_RESET:   nxt = S_FETCH;
      S_FETCH:   if (ready) nxt = S_DECODE;
      S_DECODE: begin
        if (opCode == OP_RTYPE)                     nxt = S_EXEC;
        else if (opCode == OP_LW || opCode == OP_SW) nxt = S_MEMADDR;
        else if (opCode == OP_BEQ)                  nxt = S_BRANCH;
        else if (ENABLE_JUMP && opCode == OP_J)     nxt = S_JUMP;
        else                                        nxt = S_TRAP;
      end
      S_MEMADDR: nxt = is_lw ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (ready) nxt = S_MEMWB;
      S_MEMWB:   nxt = S_FETCH;
      S_MEMWR:   if (ready) nxt = S_FETCH;
      S_EXEC:    nxt = S_RWB;
      S_RWB:     nxt = S_FETCH;
      S_BRANCH:  nxt = S_FETCH;
      S_JUMP:    nxt = S_FETCH;
      S_TRAP:    nxt = S_TRAP;
      default:   nxt = S_FETCH;
    endcase
  end

  multicycle_control_output_decode u_decode (
    .st          (cur),
    .ready       (ready),
    .pcWrite     (pcWrite),
    .pcWriteCond (pcWriteCond),
    .iorD        (iorD),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .irWrite     (irWrite),
    .memToReg    (memToReg),
    .regDest     (regDest),
    .regWrite    (regWrite),
    .aluSrcA     (aluSrcA),
    .aluSrcB     (aluSrcB),
    .aluOp       (aluOp),
    .pcSource    (pcSource),
    .illegal     (illegal),
    .instrDone   (instrDone)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: default instance (a) plus a variant instance (b)
// with jump disabled, no memory handshake and a 2-bit retire counter.
module tb_multicycle_control;

  localparam logic [5:0] T_RTYPE = 6'b000000;
  localparam logic [5:0] T_LW    = 6'b110001;
  localparam logic [5:0] T_SW    = 6'b110101;
  localparam logic [5:0] T_BEQ   = 6'b001000;
  localparam logic [5:0] T_J     = 6'b000010;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       memReady = 1'b0;
  logic [5:0] opCode = '0;

  logic a_pcWrite, a_pcWriteCond, a_iorD, a_memRead, a_memWrite, a_irWrite;
  logic a_memToReg, a_regDest, a_regWrite, a_aluSrcA, a_illegal, a_instrDone;
  logic [1:0] a_aluSrcB, a_aluOp, a_pcSource;
  logic [15:0] a_count;
  logic [3:0]  a_state;
  logic b_pcWrite, b_pcWriteCond, b_iorD, b_memRead, b_memWrite, b_irWrite;
  logic b_memToReg, b_regDest, b_regWrite, b_aluSrcA, b_illegal, b_instrDone;
  logic [1:0] b_aluSrcB, b_aluOp, b_pcSource;
  logic [1:0]  b_count;
  logic [3:0]  b_state;

  logic [21:0] a_obs, b_obs;
  assign a_obs = {a_state, a_pcWrite, a_pcWriteCond, a_iorD, a_memRead, a_memWrite, a_irWrite,
                  a_memToReg, a_regDest, a_regWrite, a_aluSrcA, a_aluSrcB, a_aluOp, a_pcSource,
                  a_illegal, a_instrDone};
  assign b_obs = {b_state, b_pcWrite, b_pcWriteCond, b_iorD, b_memRead, b_memWrite, b_irWrite,
                  b_memToReg, b_regDest, b_regWrite, b_aluSrcA, b_aluSrcB, b_aluOp, b_pcSource,
                  b_illegal, b_instrDone};

  int n_cmp = 0;
  int n_bad = 0;
  int a_ret = 0;
  int b_ret = 0;

  always #5 clock = ~clock;

  multicycle_control dut_a (
    .clock(clock), .reset(reset), .opCode(opCode), .memReady(memReady),
    .pcWrite(a_pcWrite), .pcWriteCond(a_pcWriteCond), .iorD(a_iorD), .memRead(a_memRead),
    .memWrite(a_memWrite), .irWrite(a_irWrite), .memToReg(a_memToReg), .regDest(a_regDest),
    .regWrite(a_regWrite), .aluSrcA(a_aluSrcA), .aluSrcB(a_aluSrcB), .aluOp(a_aluOp),
    .pcSource(a_pcSource), .illegal(a_illegal), .instrDone(a_instrDone),
    .retireCount(a_count), .state(a_state)
  );

  multicycle_control #(.ENABLE_JUMP(1'b0), .MEM_HANDSHAKE(1'b0), .COUNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .opCode(opCode), .memReady(memReady),
    .pcWrite(b_pcWrite), .pcWriteCond(b_pcWriteCond), .iorD(b_iorD), .memRead(b_memRead),
    .memWrite(b_memWrite), .irWrite(b_irWrite), .memToReg(b_memToReg), .regDest(b_regDest),
    .regWrite(b_regWrite), .aluSrcA(b_aluSrcA), .aluSrcB(b_aluSrcB), .aluOp(b_aluOp),
    .pcSource(b_pcSource), .illegal(b_illegal), .instrDone(b_instrDone),
    .retireCount(b_count), .state(b_state)
  );

  // Expected {state, controls} for a state code under a given memory-ready value;
  // instrDone is the LSB.
  function automatic logic [21:0] expect_obs(input int s, input logic r);
    logic pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, ill, done;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, ill, done} = '0;
    {asb, aop, psrc} = '0;
    case (s)
      1:  begin mr = 1; asb = 2'b01; irw = r; pw = r; end
      2:  asb = 2'b11;
      3:  begin asa = 1; asb = 2'b10; end
      4:  begin mr = 1; iord = 1; end
      5:  begin m2r = 1; rw = 1; done = 1; end
      6:  begin mw = 1; iord = 1; done = r; end
      7:  begin asa = 1; aop = 2'b10; end
      8:  begin rd = 1; rw = 1; done = 1; end
      9:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; done = 1; end
      10: begin pw = 1; psrc = 2'b10; done = 1; end
      15: ill = 1;
      default: ;
    endcase
    return {4'(s), pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, ill, done};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    a_ret = 0;
    b_ret = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    memReady = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    n_cmp++;
    if (a_obs !== '0 || a_count !== '0) begin
      n_bad++;
      $display("FAIL reset_a: got obs=%h cnt=%0d, want obs=0 cnt=0", a_obs, a_count);
    end
    n_cmp++;
    if (b_obs !== '0 || b_count !== '0) begin
      n_bad++;
      $display("FAIL reset_b: got obs=%h cnt=%0d, want obs=0 cnt=0", b_obs, b_count);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_rtype();
    int st[6] = '{0, 1, 2, 7, 8, 1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      opCode = T_RTYPE;
      memReady = 1'b1;
      @(negedge clock);
      n_cmp++;
      if (a_obs !== expect_obs(st[i], 1'b1)) begin
        n_bad++;
        $display("FAIL rtype cyc%0d: got %h, want %h", i, a_obs, expect_obs(st[i], 1'b1));
      end
      @(posedge clock); #1;
    end
    n_cmp++;
    if (a_count !== 16'd1) begin
      n_bad++;
      $display("FAIL rtype_count: got %0d, want 1", a_count);
    end
  endtask

  task automatic test_lw_stall();
    int   st[10]  = '{0, 1, 2, 3, 4, 4, 4, 4, 5, 1};
    logic rdy[10] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      opCode = (i == 2) ? T_LW : 6'($urandom);
      memReady = rdy[i];
      @(negedge clock);
      n_cmp++;
      if (a_obs !== expect_obs(st[i], rdy[i])) begin
        n_bad++;
        $display("FAIL lw_stall cyc%0d: got %h, want %h", i, a_obs, expect_obs(st[i], rdy[i]));
      end
      @(posedge clock); #1;
    end
    n_cmp++;
    if (a_count !== 16'd1) begin
      n_bad++;
      $display("FAIL lw_stall_count: got %0d, want 1", a_count);
    end
  endtask

  task automatic test_trap();
    int s;
    // Instance a traps on 111111; instance b traps on J because jump is disabled.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int i = 0; i < 13; i++) begin
        opCode = (pass == 0) ? 6'b111111 : T_J;
        memReady = 1'b1;
        s = (i < 3) ? i : 15;
        @(negedge clock);
        n_cmp++;
        if (((pass == 0) ? a_obs : b_obs) !== expect_obs(s, 1'b1) ||
            ((pass == 0) ? a_count : 16'(b_count)) !== 16'd0) begin
          n_bad++;
          $display("FAIL trap%0d cyc%0d: got %h, want %h", pass, i,
                   (pass == 0) ? a_obs : b_obs, expect_obs(s, 1'b1));
        end
        @(posedge clock); #1;
      end
      reset = 1'b1;
      @(posedge clock); #1;
      @(negedge clock);
      n_cmp++;
      if (((pass == 0) ? a_obs : b_obs) !== '0) begin
        n_bad++;
        $display("FAIL trap%0d_reset: got %h, want 0", pass, (pass == 0) ? a_obs : b_obs);
      end
    end
  endtask

  task automatic test_variant_wrap();
    int st[4] = '{1, 2, 7, 8};
    do_reset();
    memReady = 1'b0;
    opCode = T_RTYPE;
    @(posedge clock); #1;
    for (int n = 0; n < 5; n++) begin
      for (int p = 0; p < 4; p++) begin
        @(negedge clock);
        n_cmp++;
        if (b_obs !== expect_obs(st[p], 1'b1) || b_count !== 2'(b_ret)) begin
          n_bad++;
          $display("FAIL wrap n%0d p%0d: got obs=%h cnt=%0d, want obs=%h cnt=%0d", n, p,
                   b_obs, b_count, expect_obs(st[p], 1'b1), 2'(b_ret));
        end
        if (p == 3) b_ret++;
        @(posedge clock); #1;
      end
    end
    n_cmp++;
    if (b_count !== 2'd1) begin
      n_bad++;
      $display("FAIL wrap_final: got %0d, want 1", b_count);
    end
    // Now in FETCH; advance to EXEC and reset there.
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (b_state !== 4'd7) begin
      n_bad++;
      $display("FAIL midreset_pre: got state=%0d, want 7", b_state);
    end
    @(posedge clock); #1;
    @(negedge clock);
    n_cmp++;
    if (b_obs !== '0 || b_count !== 2'd0) begin
      n_bad++;
      $display("FAIL midreset: got obs=%h cnt=%0d, want obs=0 cnt=0", b_obs, b_count);
    end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_random();
    logic [5:0] ops[5] = '{T_RTYPE, T_LW, T_SW, T_BEQ, T_J};
    int   ph[$];
    int   pick, stalls;
    logic rdy, stallable;
    logic [21:0] want;
    do_reset();
    memReady = 1'b1;
    @(posedge clock); #1;
    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 4);
      ph = {1, 2};
      case (pick)
        0: begin ph.push_back(7); ph.push_back(8); end
        1: begin ph.push_back(3); ph.push_back(4); ph.push_back(5); end
        2: begin ph.push_back(3); ph.push_back(6); end
        3: ph.push_back(9);
        default: ph.push_back(10);
      endcase
      foreach (ph[p]) begin
        stallable = (ph[p] == 1 || ph[p] == 4 || ph[p] == 6);
        stalls = stallable ? $urandom_range(0, 2) : 0;
        for (int k = 0; k <= stalls; k++) begin
          rdy = stallable ? (k == stalls) : 1'($urandom);
          memReady = rdy;
          opCode = (ph[p] == 2) ? ops[pick] : 6'($urandom);
          @(negedge clock);
          want = expect_obs(ph[p], rdy);
          n_cmp++;
          if (a_obs !== want || a_count !== 16'(a_ret)) begin
            n_bad++;
            $display("FAIL random i%0d op%0d ph%0d: got obs=%h cnt=%0d, want obs=%h cnt=%0d",
                     n, pick, ph[p], a_obs, a_count, want, a_ret);
          end
          if (want[0]) a_ret++;
          @(posedge clock); #1;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_trap();
    test_variant_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
